dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master data memory arbiter with starvation guard and locked RMW
//
// Arbitrates a single-port data memory between a CPU and an accelerator.
// The grant is combinational, so an access issues in the same cycle it is requested.
// The CPU normally wins. The accelerator wins once it has been denied STARVE_MAX cycles in a row.
// An accelerator grant with acc_lock set holds the bus for the accelerator.
// That hold lasts for up to LOCK_MAX grants in total.
// Read data returns one cycle after issue and is tagged to the requester that issued the read.
//
// Ports:
//   clk, rst                                     clock, async active-low reset
//   cpu_req/we/addr/wdata -> cpu_stall/rvalid    CPU request side
//   acc_req/we/lock/addr/wdata -> acc_gnt/rvalid accelerator request side
//   rdata                                        shared read data, qualified by *_rvalid
//   mem_en/we/addr/wdata, mem_rdata              memory port
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic              acc_lock,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  // One spare count so the post-increment value can reach LOCK_MAX.
  localparam int LW = $clog2(LOCK_MAX + 2);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

  typedef enum logic {FREE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d, lock_cnt_inc;
  logic            cpu_tag_q, cpu_tag_d;
  logic            acc_tag_q, acc_tag_d;
  logic            cpu_gnt, acc_gnt_w;

  // Grants are qualified by rst so that every output is quiet while reset is held.
  always_comb begin
    cpu_gnt   = 1'b0;
    acc_gnt_w = 1'b0;
    if (rst) begin
      if (state_q == LOCK) begin
        acc_gnt_w = acc_req;
      end else begin
        cpu_gnt   = cpu_req && !(acc_req && (starve_cnt_q == STARVE_TOP));
        acc_gnt_w = acc_req && !cpu_gnt;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    starve_cnt_d = starve_cnt_q;
    // lock_cnt_inc is the grant count including the current cycle's grant.
    lock_cnt_inc = lock_cnt_q + LW'(1);

    if (acc_gnt_w) begin
      starve_cnt_d = '0;
    end else if (acc_req && (starve_cnt_q != STARVE_TOP)) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end

    case (state_q)
      FREE: begin
        if (acc_gnt_w && acc_lock && (LOCK_TOP > LW'(1))) begin
          state_d    = LOCK;
          lock_cnt_d = LW'(1);
        end
      end
      default: begin
        // In LOCK, acc_req alone means a grant, so reaching the cap implies a granted cycle.
        if (!acc_req || !acc_lock || (lock_cnt_inc >= LOCK_TOP)) begin
          state_d    = FREE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_inc;
        end
      end
    endcase

    cpu_tag_d = cpu_gnt && !cpu_we;
    acc_tag_d = acc_gnt_w && !acc_we;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FREE;
      starve_cnt_q <= '0;
      lock_cnt_q   <= '0;
      cpu_tag_q    <= 1'b0;
      acc_tag_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      cpu_tag_q    <= cpu_tag_d;
      acc_tag_q    <= acc_tag_d;
    end
  end

  always_comb begin
    mem_en    = cpu_gnt || acc_gnt_w;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (acc_gnt_w) begin
      mem_we    = acc_we;
      mem_addr  = acc_addr;
      mem_wdata = acc_wdata;
    end
  end

  assign acc_gnt    = acc_gnt_w;
  assign cpu_stall  = rst && cpu_req && !cpu_gnt;
  assign cpu_rvalid = cpu_tag_q;
  assign acc_rvalid = acc_tag_q;
  assign rdata      = rst ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        acc_req, acc_we, acc_lock, acc_gnt, acc_rvalid;
  logic [31:0] acc_addr, acc_wdata;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;

  int n_chk  = 0;
  int n_fail = 0;

  localparam int OWN_N = 0;
  localparam int OWN_C = 1;
  localparam int OWN_A = 2;

  typedef struct packed {
    logic        acc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
  } access_t;

  typedef struct packed {
    logic        acc;
    logic [31:0] data;
  } rd_t;

  access_t acc_q[$];
  rd_t     rd_q[$];
  access_t mon_e, mon_g;
  rd_t     mon_re, mon_rg;

  dmem_arbiter #(
    .DATA_W(32), .ADDR_W(32), .STARVE_MAX(4), .LOCK_MAX(2)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .acc_req(acc_req), .acc_we(acc_we), .acc_lock(acc_lock), .acc_addr(acc_addr),
    .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preloaded while reset is held, one-cycle read latency.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (!rst) begin
      mem[10'h040] <= 32'h0000_00A5;
      mem[10'h044] <= 32'h0000_005A;
      mem[10'd100] <= 32'h0;
      mem[10'h200] <= 32'h0000_0015;
      mem_rdata    <= 32'hDEAD_BEEF;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation for every issued access and every read return.
  always @(negedge clk) begin
    if (mem_en) begin
      n_chk++;
      mon_g = {acc_gnt, mem_we, mem_addr, mem_wdata, cpu_stall};
      if (acc_q.size() == 0) begin
        n_fail++;
        $display("FAIL access_unexpected: actual=%h required=no access", mon_g);
      end else begin
        mon_e = acc_q.pop_front();
        if (mon_g !== mon_e) begin
          n_fail++;
          $display("FAIL access {acc,we,addr,wdata,stall}: actual=%h required=%h", mon_g, mon_e);
        end
      end
    end
    if (cpu_rvalid || acc_rvalid) begin
      n_chk++;
      mon_rg = {acc_rvalid, rdata};
      if (cpu_rvalid && acc_rvalid) begin
        n_fail++;
        $display("FAIL rvalid_both: actual=11 required=one-hot");
      end else if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rvalid_unexpected: actual=%h required=no rvalid", mon_rg);
      end else begin
        mon_re = rd_q.pop_front();
        if (mon_rg !== mon_re) begin
          n_fail++;
          $display("FAIL read_return {acc,rdata}: actual=%h required=%h", mon_rg, mon_re);
        end
      end
    end
  end

  // Drives one cycle of requests (called at posedge+1) and records the expected outcome.
  task automatic cyc(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic ar, input logic aw, input logic al,
                     input logic [31:0] aa, input logic [31:0] ad,
                     input int own, input logic st, input logic [31:0] rd);
    access_t e;
    rd_t     r;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    acc_req = ar; acc_we = aw; acc_lock = al; acc_addr = aa; acc_wdata = ad;
    if (own == OWN_C) begin
      e = '{acc: 1'b0, we: cw, addr: ca, wdata: cd, stall: st};
      acc_q.push_back(e);
      if (!cw) begin
        r = '{acc: 1'b0, data: rd};
        rd_q.push_back(r);
      end
    end else if (own == OWN_A) begin
      e = '{acc: 1'b1, we: aw, addr: aa, wdata: ad, stall: st};
      acc_q.push_back(e);
      if (!aw) begin
        r = '{acc: 1'b1, data: rd};
        rd_q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    access_t e;
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd100; cpu_wdata = 32'd7;
    acc_req = 1'b1; acc_we = 1'b1; acc_lock = 1'b1; acc_addr = 32'h200; acc_wdata = 32'd5;
    @(posedge clk);
    #1;
    chk("rst_mem_en",     {31'b0, mem_en},     32'h0);
    chk("rst_mem_we",     {31'b0, mem_we},     32'h0);
    chk("rst_acc_gnt",    {31'b0, acc_gnt},    32'h0);
    chk("rst_cpu_stall",  {31'b0, cpu_stall},  32'h0);
    chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
    chk("rst_acc_rvalid", {31'b0, acc_rvalid}, 32'h0);
    chk("rst_mem_addr",   mem_addr,            32'h0);
    chk("rst_mem_wdata",  mem_wdata,           32'h0);
    chk("rst_rdata",      rdata,               32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // First cycle after reset: both request, CPU write 100 <- 7 wins.
    cyc(1, 1, 32'd100, 32'd7, 1, 0, 0, 32'h40, 0, OWN_C, 0, 0);
    // Alternating reads: acc 0x40, cpu 100, acc 0x44.
    cyc(0, 0, 0, 0,            1, 0, 0, 32'h40, 0, OWN_A, 0, 32'hA5);
    cyc(1, 0, 32'd100, 0,      0, 0, 0, 0, 0,      OWN_C, 0, 32'd7);
    cyc(0, 0, 0, 0,            1, 0, 0, 32'h44, 0, OWN_A, 0, 32'h5A);

    // Continuous contention without lock: CPU x4 then ACC, twice.
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) cyc(1, 1, 32'd8, 32'h11, 1, 1, 0, 32'd12, 32'h22, OWN_A, 1, 0);
      else            cyc(1, 1, 32'd8, 32'h11, 1, 1, 0, 32'd12, 32'h22, OWN_C, 0, 0);
    end

    // Locked read-modify-write, reached through starvation.
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 32'd16, 32'd1, 1, 0, 1, 32'h200, 0, OWN_C, 0, 0);
    cyc(1, 1, 32'd16, 32'd1, 1, 0, 1, 32'h200, 0,      OWN_A, 1, 32'h15);
    cyc(1, 1, 32'd16, 32'd1, 1, 1, 1, 32'h200, 32'h16, OWN_A, 1, 0);

    // Lock held continuously: CPU x4, two ACC grants, forced FREE, CPU.
    for (int i = 0; i < 7; i++) begin
      if (i == 4 || i == 5) cyc(1, 1, 32'd20, 32'd9, 1, 1, 1, 32'h300, 32'hAB, OWN_A, 1, 0);
      else                  cyc(1, 1, 32'd20, 32'd9, 1, 1, 1, 32'h300, 32'hAB, OWN_C, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, OWN_N, 0, 0);

    // Reset during LOCK with a read outstanding.
    cyc(0, 0, 0, 0, 1, 0, 1, 32'h200, 0, OWN_A, 0, 32'h16);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd24; cpu_wdata = 32'd5;
    acc_req = 1'b1; acc_we = 1'b0; acc_lock = 1'b1; acc_addr = 32'h200; acc_wdata = 32'd0;
    #1;
    chk("lock_acc_gnt_pre",    {31'b0, acc_gnt},    32'h1);
    chk("lock_acc_rvalid_pre", {31'b0, acc_rvalid}, 32'h1);
    rst = 1'b0;
    rd_q.delete();
    #1;
    chk("async_acc_gnt",    {31'b0, acc_gnt},    32'h0);
    chk("async_acc_rvalid", {31'b0, acc_rvalid}, 32'h0);
    chk("async_mem_en",     {31'b0, mem_en},     32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    e = '{acc: 1'b0, we: 1'b1, addr: 32'd24, wdata: 32'd5, stall: 1'b0};
    acc_q.push_back(e);
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, OWN_N, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, OWN_N, 0, 0);

    chk("access_queue_drained", acc_q.size(), 32'd0);
    chk("read_queue_drained",   rd_q.size(),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
